ai_i2s_frame_deserializer: RTL and testbench
============================================

Name: ai_i2s_frame_deserializer

Overview:
- Stereo I2S receive deserializer: samples serial data on a bit-clock-rate strobe and frames words on word-select (WS) edges.
- Supports I2S, left-justified and right-justified formats with runtime word length.
- Tags each word with its channel and buffers it in a small FIFO with a valid/ready output handshake.
- Sits between the I2S pin synchroniser / SCK edge detector and the RX sample FIFO / DMA interface.

Parameters:
- DATA_WIDTH, 32, maximum word width and width of data_out.
- FIFO_DEPTH, 4, output buffer entries; power of two, at least 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  block enable; low flushes all state
- clk_en  in  1  single-cycle strobe marking the SCK sampling edge
- sd  in  1  serial data, synchronised
- ws  in  1  word select, synchronised; 0 = left (ch 0), 1 = right (ch 1)
- mode  in  2  00 I2S, 01 left-justified, 10 right-justified, 11 treated as I2S
- num_bits  in  6  word length; 0 or greater than DATA_WIDTH means DATA_WIDTH
- data_out  out  DATA_WIDTH  word, right-aligned, upper bits zero
- ch_id  out  1  channel of data_out
- valid  out  1  FIFO head valid
- ready  in  1  consumer accepts head when valid and ready
- overflow  out  1  sticky: word dropped because FIFO was full
- frame_err  out  1  sticky: WS edge arrived before num_bits collected (I2S or LJ)

Behaviour:
- Reset or enable low clears every register to zero: data_out 0, ch_id 0, valid 0, overflow 0, frame_err 0. FIFO empty, FSM in SYNC.
- All sampling happens only on cycles where clk_en is high. ws_prev is the ws value from the previous strobe; an edge is ws != ws_prev.
- mode and num_bits are latched on the SYNC exit. Changes take effect only after enable is toggled.
- FSM states: SYNC, DELAY, SHIFT, WAIT.
  - SYNC: ignore sd until the first WS edge, so no partial word is ever emitted after enable.
    - Edge with I2S: go to DELAY.
    - Edge with LJ: treat the current bit as the MSB and go to SHIFT.
    - Edge with RJ: go to SHIFT.
  - DELAY: skip one bit (the I2S one-bit delay), then SHIFT. Channel is the new ws value.
  - SHIFT for I2S/LJ: shift sd in MSB first and count bits.
    - When the count reaches num_bits, capture the word and go to WAIT.
    - A WS edge before that: discard the partial word, set frame_err, restart per mode on that edge.
  - WAIT: ignore extra slot bits. On the next WS edge, restart per mode (DELAY for I2S, SHIFT for LJ).
  - SHIFT for RJ: shift continuously. On each WS edge, capture the low num_bits of the shift register (including the bit sampled on the strobe before the edge) with ch_id = ws_prev. Then clear the count and stay in SHIFT.
- Capture writes the FIFO in the same clk cycle as the strobe. valid rises on the next clk if the FIFO was empty (1-cycle latency).
- Capture while the FIFO is full: drop the new word, keep FIFO contents, set overflow.
- Capture and pop in the same cycle when the FIFO is full: the pop frees a slot and the word is accepted, no overflow.
- Capture into an empty FIFO with ready high: the word still appears on data_out for at least one cycle (no fall-through).
- data_out and ch_id are stable while valid is high and ready is low.
- enable dropping mid-word: flush on the next clk and return to SYNC.
- Bit counter is 6 bits. Shift register is DATA_WIDTH bits; bits above num_bits are masked to zero on capture.

Decomposition:
- Package ai_i2s_pkg holds:
  - typedef i2s_mode_e (I2S_STD, I2S_LJ, I2S_RJ).
  - typedef rx_state_e (SYNC, DELAY, SHIFT, WAIT).
  - Constants CH_LEFT = 0 and CH_RIGHT = 1.
- Sub-module ai_i2s_rx_fifo: synchronous FIFO of {ch_id, data}, parameterised by width and depth. It provides full, empty, push, pop, an async active-low reset, and a synchronous flush driven by enable low.

Test Plan:
- I2S, num_bits=16, 32-bit slots, left 0xA5C3, right 0x1234, ready=1 -> words 0x0000A5C3 ch0 then 0x00001234 ch1; first partial frame after enable not emitted.
- LJ, num_bits=24, left 0xABCDEF with MSB on the WS-edge bit -> data_out 0x00ABCDEF, ch_id 0; slot padding bits ignored.
- RJ, num_bits=20, 32-bit slots, last 20 bits of right slot 0xF00D5 -> data_out 0x000F00D5, ch_id 1, valid one clk after the WS-edge strobe.
- ready=0, FIFO_DEPTH=4, 6 words streamed -> first 4 held in order, words 5 and 6 dropped, overflow=1; then ready=1 drains the 4 words intact.
- I2S, num_bits=24 with 16-bit slots -> no word emitted, frame_err=1.
- Reset (rst_n low) mid-word, then separately enable low mid-word -> all outputs 0, FIFO empty; next valid word only after a fresh WS edge.

Source files
------------

// File: rtl/ai_i2s_pkg.sv
// Shared types and helpers for the I2S receive deserializer.
//   i2s_mode_e  : decoded serial format (I2S / left-justified / right-justified)
//   rx_state_e  : framing FSM states
//   CH_LEFT/RIGHT : channel tags carried with each word
//   decode_mode : maps the 2-bit mode input to i2s_mode_e (11 falls back to I2S)
//   eff_bits    : resolves the runtime word length (0 or oversize -> max width)
package ai_i2s_pkg;

  typedef enum logic [1:0] {
    I2S_STD = 2'b00,
    I2S_LJ  = 2'b01,
    I2S_RJ  = 2'b10
  } i2s_mode_e;

  typedef enum logic [1:0] {
    SYNC  = 2'b00,
    DELAY = 2'b01,
    SHIFT = 2'b10,
    WAIT  = 2'b11
  } rx_state_e;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  // Width of the bit counter and of the num_bits input.
  localparam int CNT_W = 6;

  function automatic i2s_mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   return I2S_LJ;
      2'b10:   return I2S_RJ;
      default: return I2S_STD;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] eff_bits(input logic [CNT_W-1:0] nb,
                                                input int max_bits);
    if (nb == '0 || int'(nb) > max_bits) return CNT_W'(max_bits);
    return nb;
  endfunction

endpackage

// File: rtl/ai_i2s_rx_fifo.sv
// Small synchronous FIFO holding {ch_id, data} words between the framer and
// the consumer. Head entry is presented combinationally on rdata.
//   clk, rst_n : clock, async active-low reset
//   flush      : synchronous clear of pointers/count (block disabled)
//   push/wdata : write request; accepted when not full, or full with a pop
//   pop        : remove head (ignored when empty)
//   rdata      : head entry (contents undefined while empty)
//   full/empty : occupancy flags
module ai_i2s_rx_fifo
  import ai_i2s_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: the storage array has no reset; only pointers/count do. Stale
  // contents are never observable because the head is gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ai_i2s_frame_deserializer.sv
// Stereo I2S receive deserializer. Samples sd/ws on clk_en strobes, frames
// words on WS edges in I2S, left-justified or right-justified format, tags
// each word with its channel and queues it for a valid/ready consumer.
//   clk, rst_n  : clock, async active-low reset
//   enable      : low flushes all state and returns the framer to SYNC
//   clk_en      : one-cycle strobe at the SCK sampling edge
//   sd, ws      : synchronised serial data / word select (0 = left)
//   mode        : 00 I2S, 01 LJ, 10 RJ, 11 I2S
//   num_bits    : word length, 0 or > DATA_WIDTH means DATA_WIDTH
//   data_out    : right-aligned word at FIFO head (0 when empty)
//   ch_id       : channel of data_out
//   valid/ready : output handshake
//   overflow    : sticky, a word was dropped on a full FIFO
//   frame_err   : sticky, WS edge before num_bits collected (I2S/LJ)
// DATA_WIDTH must fit the 6-bit counter (2..63).
module ai_i2s_frame_deserializer
  import ai_i2s_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  clk_en,
  input  logic                  sd,
  input  logic                  ws,
  input  logic [1:0]            mode,
  input  logic [CNT_W-1:0]      num_bits,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  ch_id,
  output logic                  valid,
  input  logic                  ready,
  output logic                  overflow,
  output logic                  frame_err
);

  rx_state_e             state;
  i2s_mode_e             mode_q;
  logic [CNT_W-1:0]      nbits_q;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  ch_q;
  logic                  ws_prev;
  logic                  ws_seen;   // ws_prev holds a real sample

  i2s_mode_e             mode_sel;
  logic [CNT_W-1:0]      bits_sel;
  logic                  ws_edge;
  logic [DATA_WIDTH-1:0] sh_next;
  logic [DATA_WIDTH-1:0] first_word;
  logic                  restart;
  logic                  lj_first;
  logic                  dly_first;
  logic                  shift_done;
  logic                  rj_cap;
  logic                  cap_push;
  logic [DATA_WIDTH-1:0] cap_data;
  logic                  cap_ch;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [DATA_WIDTH:0]   fifo_head;

  function automatic logic [DATA_WIDTH-1:0] low_mask(input logic [CNT_W-1:0] n);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i < int'(n)) m[i] = 1'b1;
    end
    return m;
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    // While in SYNC the live inputs apply; they are latched on SYNC exit.
    mode_sel   = (state == SYNC) ? decode_mode(mode) : mode_q;
    bits_sel   = (state == SYNC) ? eff_bits(num_bits, DATA_WIDTH) : nbits_q;
    ws_edge    = ws_seen && (ws != ws_prev);
    sh_next    = {shreg[DATA_WIDTH-2:0], sd};
    first_word = DATA_WIDTH'(sd);

    // A WS edge that (re)starts a word. RJ in SHIFT captures instead.
    restart    = clk_en && ws_edge &&
                 (state == SYNC || state == WAIT ||
                  (state == SHIFT && mode_sel != I2S_RJ));
    // The LJ edge bit is the MSB; in I2S the edge bit is the delay slot, so
    // the MSB is the first strobe seen in DELAY.
    lj_first   = restart && (mode_sel == I2S_LJ);
    dly_first  = clk_en && !ws_edge && (state == DELAY);
    shift_done = clk_en && !ws_edge && (state == SHIFT) &&
                 (mode_sel != I2S_RJ) && (bit_cnt + 1'b1 == bits_sel);
    rj_cap     = clk_en && ws_edge && (state == SHIFT) && (mode_sel == I2S_RJ);

    cap_push = 1'b0;
    cap_data = '0;
    cap_ch   = ch_q;
    if (enable) begin
      if (rj_cap) begin
        // Word ended with the bit sampled on the previous strobe.
        cap_push = 1'b1;
        cap_data = shreg & low_mask(bits_sel);
        cap_ch   = ws_prev;
      end else if (shift_done) begin
        cap_push = 1'b1;
        cap_data = sh_next & low_mask(bits_sel);
      end else if ((lj_first || dly_first) && bits_sel == CNT_W'(1)) begin
        cap_push = 1'b1;
        cap_data = first_word;
        cap_ch   = lj_first ? ws : ch_q;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SYNC;
      mode_q    <= I2S_STD;
      nbits_q   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      ch_q      <= CH_LEFT;
      ws_prev   <= 1'b0;
      ws_seen   <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else if (!enable) begin
      state     <= SYNC;
      mode_q    <= I2S_STD;
      nbits_q   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      ch_q      <= CH_LEFT;
      ws_prev   <= 1'b0;
      ws_seen   <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (cap_push && fifo_full && !fifo_pop) overflow <= 1'b1;

      if (clk_en) begin
        ws_prev <= ws;
        ws_seen <= 1'b1;

        if (restart) begin
          if (state == SYNC) begin
            mode_q  <= mode_sel;
            nbits_q <= bits_sel;
          end
          if (state == SHIFT) frame_err <= 1'b1;  // partial word discarded
          ch_q <= ws;
          case (mode_sel)
            I2S_LJ: begin
              shreg   <= first_word;
              bit_cnt <= CNT_W'(1);
              state   <= (bits_sel == CNT_W'(1)) ? WAIT : SHIFT;
            end
            I2S_RJ: begin
              shreg   <= first_word;
              bit_cnt <= '0;
              state   <= SHIFT;
            end
            default: begin
              shreg   <= '0;
              bit_cnt <= '0;
              state   <= DELAY;
            end
          endcase
        end else begin
          case (state)
            DELAY: begin
              if (ws_edge) begin
                ch_q <= ws;
              end else begin
                shreg   <= first_word;
                bit_cnt <= CNT_W'(1);
                state   <= (bits_sel == CNT_W'(1)) ? WAIT : SHIFT;
              end
            end
            SHIFT: begin
              shreg <= sh_next;
              if (mode_q == I2S_RJ) begin
                if (ws_edge)              bit_cnt <= '0;
                else if (bit_cnt != '1)   bit_cnt <= bit_cnt + 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                if (shift_done) state <= WAIT;
              end
            end
            default: ;  // SYNC / WAIT: ignore bits until a WS edge
          endcase
        end
      end
    end
  end

  assign fifo_pop = ready && !fifo_empty;

  ai_i2s_rx_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (!enable),
    .push  (cap_push),
    .wdata ({cap_ch, cap_data}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign valid    = !fifo_empty;
  assign data_out = fifo_empty ? '0 : fifo_head[DATA_WIDTH-1:0];
  assign ch_id    = fifo_empty ? CH_LEFT : fifo_head[DATA_WIDTH];

endmodule

// File: tb/tb_ai_i2s_frame_deserializer.sv
// Directed bench for ai_i2s_frame_deserializer: builds ws/sd bit streams for
// each format, plays them on clk_en strobes and compares outputs with
// hand-computed words.
module tb_ai_i2s_frame_deserializer;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        clk_en;
  logic        sd;
  logic        ws;
  logic [1:0]  mode;
  logic [5:0]  num_bits;
  logic [31:0] data_out;
  logic        ch_id;
  logic        valid;
  logic        ready;
  logic        overflow;
  logic        frame_err;

  int checks = 0;
  int errors = 0;

  logic        ws_q[$];
  logic        sd_q[$];
  logic [32:0] obs_q[$];

  ai_i2s_frame_deserializer #(
    .DATA_WIDTH (32),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .clk_en    (clk_en),
    .sd        (sd),
    .ws        (ws),
    .mode      (mode),
    .num_bits  (num_bits),
    .data_out  (data_out),
    .ch_id     (ch_id),
    .valid     (valid),
    .ready     (ready),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted word; inputs only change at negedge or posedge+1.
  always @(negedge clk) begin
    if (valid && ready) obs_q.push_back({ch_id, data_out});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] word_at(input int i);
    if (i < obs_q.size()) return 64'(obs_q[i]);
    return 64'hDEAD_0000_0000_0000;
  endfunction

  task automatic strobe(input logic w, input logic d);
    @(negedge clk);
    ws = w; sd = d; clk_en = 1'b1;
    @(negedge clk);
    clk_en = 1'b0;
    @(negedge clk);
  endtask

  // Append one WS slot; data is MSB-first at the slot start (LJ layout) or
  // at the slot end (RJ layout); remaining slot bits carry pad.
  task automatic add_slot(input logic w, input logic [31:0] val, input int nb,
                          input int slot, input bit rj, input logic pad);
    for (int i = 0; i < slot; i++) begin
      ws_q.push_back(w);
      if (!rj) sd_q.push_back((i < nb) ? val[nb-1-i] : pad);
      else     sd_q.push_back((i >= slot - nb) ? val[slot-1-i] : pad);
    end
  endtask

  // I2S delays data one bit behind WS.
  task automatic play(input bit i2s_delay);
    if (i2s_delay) sd_q.push_front(1'b0);
    while (ws_q.size() > 0) strobe(ws_q.pop_front(), sd_q.pop_front());
    sd_q.delete();
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 ready = v;
  endtask

  task automatic reenable(input logic [1:0] m, input logic [5:0] nb);
    @(negedge clk);
    enable = 1'b0; mode = m; num_bits = nb;
    repeat (2) @(negedge clk);
    enable = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; clk_en = 1'b0; sd = 1'b0; ws = 1'b0;
    mode = 2'b00; num_bits = 6'd0; ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst data_out", data_out, 0);
    check("rst valid", valid, 0);
    check("rst ch_id", ch_id, 0);
    check("rst overflow", overflow, 0);
    check("rst frame_err", frame_err, 0);
    rst_n = 1'b1;

    // I2S, 16-bit words in 32-bit slots, after a partial right slot.
    reenable(2'b00, 6'd16);
    set_ready(1'b1);
    obs_q.delete();
    add_slot(1'b1, 32'h3FF, 10, 10, 1'b0, 1'b1);
    add_slot(1'b0, 32'hA5C3, 16, 32, 1'b0, 1'b0);
    add_slot(1'b1, 32'h1234, 16, 32, 1'b0, 1'b0);
    add_slot(1'b0, 32'h0, 0, 4, 1'b0, 1'b0);
    play(1'b1);
    repeat (4) @(negedge clk);
    check("i2s count", obs_q.size(), 2);
    check("i2s word0", word_at(0), {31'd0, 1'b0, 32'h0000A5C3});
    check("i2s word1", word_at(1), {31'd0, 1'b1, 32'h00001234});
    check("i2s frame_err", frame_err, 0);

    // Left-justified, 24-bit words, padding bits set to 1.
    reenable(2'b01, 6'd24);
    obs_q.delete();
    add_slot(1'b1, 32'h1F, 5, 5, 1'b0, 1'b1);
    add_slot(1'b0, 32'hABCDEF, 24, 32, 1'b0, 1'b1);
    add_slot(1'b1, 32'h654321, 24, 32, 1'b0, 1'b1);
    add_slot(1'b0, 32'h0, 0, 4, 1'b0, 1'b0);
    play(1'b0);
    repeat (4) @(negedge clk);
    check("lj count", obs_q.size(), 2);
    check("lj word0", word_at(0), {31'd0, 1'b0, 32'h00ABCDEF});
    check("lj word1", word_at(1), {31'd0, 1'b1, 32'h00654321});
    check("lj frame_err", frame_err, 0);

    // Right-justified, 20 bits at the end of a 32-bit right slot.
    reenable(2'b10, 6'd20);
    set_ready(1'b0);
    add_slot(1'b0, 32'h0, 0, 6, 1'b0, 1'b1);
    add_slot(1'b1, 32'hF00D5, 20, 32, 1'b1, 1'b1);
    play(1'b0);
    check("rj valid before edge", valid, 0);
    @(negedge clk);
    ws = 1'b0; sd = 1'b1; clk_en = 1'b1;
    @(negedge clk);
    clk_en = 1'b0;
    check("rj valid 1clk", valid, 1);
    check("rj data", data_out, 32'h000F00D5);
    check("rj ch_id", ch_id, 1);
    set_ready(1'b1);
    repeat (3) @(negedge clk);

    // Overflow: six 8-bit LJ words into a 4-entry FIFO with ready low.
    reenable(2'b01, 6'd8);
    set_ready(1'b0);
    obs_q.delete();
    add_slot(1'b1, 32'h0, 0, 2, 1'b0, 1'b1);
    add_slot(1'b0, 32'h11, 8, 8, 1'b0, 1'b0);
    add_slot(1'b1, 32'h22, 8, 8, 1'b0, 1'b0);
    add_slot(1'b0, 32'h33, 8, 8, 1'b0, 1'b0);
    add_slot(1'b1, 32'h44, 8, 8, 1'b0, 1'b0);
    add_slot(1'b0, 32'h55, 8, 8, 1'b0, 1'b0);
    add_slot(1'b1, 32'h66, 8, 8, 1'b0, 1'b0);
    play(1'b0);
    repeat (2) @(negedge clk);
    check("ovf flag", overflow, 1);
    check("ovf head valid", valid, 1);
    check("ovf head data", data_out, 32'h11);
    check("ovf head ch", ch_id, 0);
    set_ready(1'b1);
    repeat (10) @(negedge clk);
    check("ovf drain count", obs_q.size(), 4);
    check("ovf drain w0", word_at(0), {31'd0, 1'b0, 32'h11});
    check("ovf drain w1", word_at(1), {31'd0, 1'b1, 32'h22});
    check("ovf drain w2", word_at(2), {31'd0, 1'b0, 32'h33});
    check("ovf drain w3", word_at(3), {31'd0, 1'b1, 32'h44});
    check("ovf drained valid", valid, 0);
    check("ovf sticky", overflow, 1);

    // I2S 24-bit words in 16-bit slots: every word cut short.
    reenable(2'b00, 6'd24);
    obs_q.delete();
    add_slot(1'b1, 32'h0, 0, 3, 1'b0, 1'b1);
    add_slot(1'b0, 32'hFFFF, 16, 16, 1'b0, 1'b0);
    add_slot(1'b1, 32'h5A5A, 16, 16, 1'b0, 1'b0);
    add_slot(1'b0, 32'h0, 0, 2, 1'b0, 1'b0);
    play(1'b1);
    repeat (4) @(negedge clk);
    check("ferr flag", frame_err, 1);
    check("ferr no words", obs_q.size(), 0);
    check("ferr overflow cleared", overflow, 0);

    // Reset in the middle of a word, with a word already queued.
    reenable(2'b00, 6'd16);
    set_ready(1'b0);
    obs_q.delete();
    add_slot(1'b1, 32'h0, 0, 3, 1'b0, 1'b1);
    add_slot(1'b0, 32'h1111, 16, 32, 1'b0, 1'b0);
    add_slot(1'b1, 32'h2222, 16, 8, 1'b0, 1'b0);
    play(1'b1);
    check("pre-rst head", data_out, 32'h1111);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid rst valid", valid, 0);
    check("mid rst data", data_out, 0);
    check("mid rst ch", ch_id, 0);
    check("mid rst ferr", frame_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    add_slot(1'b1, 32'h22, 8, 24, 1'b0, 1'b0);
    add_slot(1'b0, 32'hBEEF, 16, 32, 1'b0, 1'b0);
    play(1'b1);
    check("post-rst valid", valid, 1);
    check("post-rst data", data_out, 32'h0000BEEF);
    check("post-rst ch", ch_id, 0);
    set_ready(1'b1);
    repeat (4) @(negedge clk);
    check("post-rst count", obs_q.size(), 1);

    // enable dropped in the middle of a word, with a word already queued.
    set_ready(1'b0);
    obs_q.delete();
    add_slot(1'b1, 32'h3333, 16, 32, 1'b0, 1'b0);
    add_slot(1'b0, 32'h4444, 16, 8, 1'b0, 1'b0);
    play(1'b1);
    check("pre-dis head", data_out, 32'h3333);
    check("pre-dis ch", ch_id, 1);
    @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("dis valid", valid, 0);
    check("dis data", data_out, 0);
    check("dis ch", ch_id, 0);
    enable = 1'b1;
    add_slot(1'b0, 32'h44, 8, 24, 1'b0, 1'b0);
    add_slot(1'b1, 32'hCAFE, 16, 32, 1'b0, 1'b0);
    play(1'b1);
    check("post-dis data", data_out, 32'h0000CAFE);
    check("post-dis ch", ch_id, 1);
    check("post-dis ferr", frame_err, 0);
    set_ready(1'b1);
    repeat (4) @(negedge clk);
    check("post-dis count", obs_q.size(), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
